// File: rtl/seq_detector_param_if.sv
// Bus bundle for seq_detector_param: pattern load, serial data input and detector status outputs.
// The master drives the configuration and data; the slave (the detector) drives the status.
interface seq_detector_param_if #(
  parameter int MAX_LEN = 8,
  parameter int CNT_W   = 8
);
  localparam int LW = $clog2(MAX_LEN + 1);

  logic               load;
  logic [MAX_LEN-1:0] pattern;
  logic [LW-1:0]      pat_len;
  logic               overlap;
  logic               in_valid;
  logic               w;
  logic               clr_cnt;
  logic               match;
  logic [CNT_W-1:0]   match_count;
  logic [1:0]         state;
  logic [LW-1:0]      fill;

  modport master (
    output load, pattern, pat_len, overlap, in_valid, w, clr_cnt,
    input  match, match_count, state, fill
  );

  modport slave (
    input  load, pattern, pat_len, overlap, in_valid, w, clr_cnt,
    output match, match_count, state, fill
  );
endinterface

// File: rtl/seq_detector_param.sv
// Serial detector for a runtime-loaded pattern of 1..MAX_LEN bits, with overlapping or
// non-overlapping matching and a saturating match counter.
module seq_detector_param #(
  parameter int MAX_LEN = 8,
  parameter int CNT_W   = 8
) (
  input logic                  clock,
  input logic                  resetn,
  seq_detector_param_if.slave  bus
);
  localparam int LW = $clog2(MAX_LEN + 1);

  typedef enum logic [1:0] {
    UNCFG = 2'd0,
    FILL  = 2'd1,
    ARMED = 2'd2
  } state_t;

  state_t             state_q, state_d;
  // The oldest history bit only ever appears in the post-shift compare window, so it is not stored.
  logic [MAX_LEN-2:0] hist_q, hist_d;
  logic [LW-1:0]      len_q, len_d;
  logic [MAX_LEN-1:0] pat_q, pat_d;
  logic               ovl_q, ovl_d;
  logic [LW-1:0]      fill_q, fill_d;
  logic               match_q, match_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic [MAX_LEN-1:0] hist_shift;
  logic [MAX_LEN-1:0] mask;
  logic [LW-1:0]      fill_inc;
  logic [LW-1:0]      len_clamped;
  logic               hit;

  always_comb begin
    mask = '0;
    for (int i = 0; i < MAX_LEN; i++) begin
      mask[i] = (LW'(i) < len_q);
    end
  end

  always_comb begin
    hist_shift  = {hist_q, bus.w};
    fill_inc    = (fill_q < len_q) ? fill_q + LW'(1) : len_q;
    len_clamped = (bus.pat_len > LW'(MAX_LEN)) ? LW'(MAX_LEN) : bus.pat_len;
    hit         = (fill_inc == len_q) && ((hist_shift & mask) == (pat_q & mask));
  end

  // A zero-length load is treated as no load at all, so data shifting proceeds normally that cycle.
  always_comb begin
    state_d = state_q;
    hist_d  = hist_q;
    len_d   = len_q;
    pat_d   = pat_q;
    ovl_d   = ovl_q;
    fill_d  = fill_q;
    match_d = 1'b0;
    cnt_d   = cnt_q;

    if (bus.load && (bus.pat_len != '0)) begin
      len_d   = len_clamped;
      pat_d   = bus.pattern;
      ovl_d   = bus.overlap;
      hist_d  = '0;
      fill_d  = '0;
      state_d = FILL;
    end else if (bus.in_valid && (state_q != UNCFG)) begin
      hist_d = hist_shift[MAX_LEN-2:0];
      fill_d = fill_inc;
      if (hit) begin
        match_d = 1'b1;
        cnt_d   = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + CNT_W'(1);
        if (ovl_q) begin
          state_d = ARMED;
        end else begin
          hist_d  = '0;
          fill_d  = '0;
          state_d = FILL;
        end
      end else begin
        state_d = (fill_inc == len_q) ? ARMED : FILL;
      end
    end

    if (bus.clr_cnt) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q <= UNCFG;
      hist_q  <= '0;
      len_q   <= '0;
      pat_q   <= '0;
      ovl_q   <= 1'b0;
      fill_q  <= '0;
      match_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      hist_q  <= hist_d;
      len_q   <= len_d;
      pat_q   <= pat_d;
      ovl_q   <= ovl_d;
      fill_q  <= fill_d;
      match_q <= match_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.match       = match_q;
  assign bus.match_count = cnt_q;
  assign bus.state       = state_q;
  assign bus.fill        = fill_q;
endmodule

// File: tb/tb_seq_detector_param.sv
// Directed table-driven bench for seq_detector_param (MAX_LEN=8, CNT_W=2 so saturation is reachable),
// plus hand-written sequences around asynchronous reset.
module tb_seq_detector_param;
  localparam int MAX_LEN = 8;
  localparam int CNT_W   = 2;
  localparam int LW      = $clog2(MAX_LEN + 1);

  logic clock;
  logic resetn;

  seq_detector_param_if #(.MAX_LEN(MAX_LEN), .CNT_W(CNT_W)) bus ();

  seq_detector_param #(.MAX_LEN(MAX_LEN), .CNT_W(CNT_W)) dut (
    .clock  (clock),
    .resetn (resetn),
    .bus    (bus)
  );

  typedef struct {
    logic               load;
    logic [MAX_LEN-1:0] pattern;
    logic [LW-1:0]      pat_len;
    logic               overlap;
    logic               in_valid;
    logic               w;
    logic               clr_cnt;
    logic               exp_match;
    logic [CNT_W-1:0]   exp_count;
    logic [1:0]         exp_state;
    logic [LW-1:0]      exp_fill;
  } vec_t;

  vec_t vecs[$];
  int   checks = 0;
  int   errors = 0;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic vec_t mk(input logic ld, input logic [MAX_LEN-1:0] pat, input logic [LW-1:0] plen,
                              input logic ovl, input logic iv, input logic wb, input logic clr,
                              input logic em, input logic [CNT_W-1:0] ec, input logic [1:0] est,
                              input logic [LW-1:0] ef);
    vec_t v;
    v.load = ld; v.pattern = pat; v.pat_len = plen; v.overlap = ovl;
    v.in_valid = iv; v.w = wb; v.clr_cnt = clr;
    v.exp_match = em; v.exp_count = ec; v.exp_state = est; v.exp_fill = ef;
    return v;
  endfunction

  // Drives one cycle of inputs and leaves time 1 unit after the sampling edge.
  task automatic applyStimulus(input vec_t v);
    bus.load     = v.load;
    bus.pattern  = v.pattern;
    bus.pat_len  = v.pat_len;
    bus.overlap  = v.overlap;
    bus.in_valid = v.in_valid;
    bus.w        = v.w;
    bus.clr_cnt  = v.clr_cnt;
    @(posedge clock);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic em, input logic [CNT_W-1:0] ec,
                             input logic [1:0] est, input logic [LW-1:0] ef);
    checks++;
    if (bus.match !== em) begin
      errors++;
      $display("[TB] FAIL %s.match: got %0b expected %0b", tag, bus.match, em);
    end
    checks++;
    if (bus.match_count !== ec) begin
      errors++;
      $display("[TB] FAIL %s.match_count: got %0d expected %0d", tag, bus.match_count, ec);
    end
    checks++;
    if (bus.state !== est) begin
      errors++;
      $display("[TB] FAIL %s.state: got %0d expected %0d", tag, bus.state, est);
    end
    checks++;
    if (bus.fill !== ef) begin
      errors++;
      $display("[TB] FAIL %s.fill: got %0d expected %0d", tag, bus.fill, ef);
    end
  endtask

  initial begin
    //              ld pattern      len  ov iv w  clr  m  cnt st fill
    // Overlapping 1101: matches after bits 4 and 7
    vecs.push_back(mk(1, 8'b00001101, 4'd4, 1, 0, 0, 0,   0, 2'd0, 2'd1, 4'd0));
    vecs.push_back(mk(0, 8'h00,       4'd0, 0, 1, 1, 0,   0, 2'd0, 2'd1, 4'd1));
    vecs.push_back(mk(0, 8'h00,       4'd0, 0, 1, 1, 0,   0, 2'd0, 2'd1, 4'd2));
    vecs.push_back(mk(0, 8'h00,       4'd0, 0, 1, 0, 0,   0, 2'd0, 2'd1, 4'd3));
    vecs.push_back(mk(0, 8'h00,       4'd0, 0, 1, 1, 0,   1, 2'd1, 2'd2, 4'd4));
    vecs.push_back(mk(0, 8'h00,       4'd0, 0, 1, 1, 0,   0, 2'd1, 2'd2, 4'd4));
    vecs.push_back(mk(0, 8'h00,       4'd0, 0, 1, 0, 0,   0, 2'd1, 2'd2, 4'd4));
    vecs.push_back(mk(0, 8'h00,       4'd0, 0, 1, 1, 0,   1, 2'd2, 2'd2, 4'd4));
    vecs.push_back(mk(0, 8'h00,       4'd0, 0, 0, 0, 0,   0, 2'd2, 2'd2, 4'd4));
    // Zero-length load while ARMED is ignored; then a plain counter clear
    vecs.push_back(mk(1, 8'hFF,       4'd0, 0, 0, 0, 0,   0, 2'd2, 2'd2, 4'd4));
    vecs.push_back(mk(0, 8'h00,       4'd0, 0, 0, 0, 1,   0, 2'd0, 2'd2, 4'd4));
    // Non-overlapping 1101, same stream: one match, ends FILL with fill 3
    vecs.push_back(mk(1, 8'b00001101, 4'd4, 0, 0, 0, 0,   0, 2'd0, 2'd1, 4'd0));
    vecs.push_back(mk(0, 8'h00,       4'd0, 0, 1, 1, 0,   0, 2'd0, 2'd1, 4'd1));
    vecs.push_back(mk(0, 8'h00,       4'd0, 0, 1, 1, 0,   0, 2'd0, 2'd1, 4'd2));
    vecs.push_back(mk(0, 8'h00,       4'd0, 0, 1, 0, 0,   0, 2'd0, 2'd1, 4'd3));
    vecs.push_back(mk(0, 8'h00,       4'd0, 0, 1, 1, 0,   1, 2'd1, 2'd1, 4'd0));
    vecs.push_back(mk(0, 8'h00,       4'd0, 0, 1, 1, 0,   0, 2'd1, 2'd1, 4'd1));
    vecs.push_back(mk(0, 8'h00,       4'd0, 0, 1, 0, 0,   0, 2'd1, 2'd1, 4'd2));
    vecs.push_back(mk(0, 8'h00,       4'd0, 0, 1, 1, 0,   0, 2'd1, 2'd1, 4'd3));
    // pat_len 12 clamps to 8: pattern 10110011 matches only on the 8th bit
    vecs.push_back(mk(1, 8'b10110011, 4'd12, 0, 0, 0, 0,  0, 2'd1, 2'd1, 4'd0));
    vecs.push_back(mk(0, 8'h00,       4'd0, 0, 1, 1, 0,   0, 2'd1, 2'd1, 4'd1));
    vecs.push_back(mk(0, 8'h00,       4'd0, 0, 1, 0, 0,   0, 2'd1, 2'd1, 4'd2));
    vecs.push_back(mk(0, 8'h00,       4'd0, 0, 1, 1, 0,   0, 2'd1, 2'd1, 4'd3));
    vecs.push_back(mk(0, 8'h00,       4'd0, 0, 1, 1, 0,   0, 2'd1, 2'd1, 4'd4));
    vecs.push_back(mk(0, 8'h00,       4'd0, 0, 1, 0, 0,   0, 2'd1, 2'd1, 4'd5));
    vecs.push_back(mk(0, 8'h00,       4'd0, 0, 1, 0, 0,   0, 2'd1, 2'd1, 4'd6));
    vecs.push_back(mk(0, 8'h00,       4'd0, 0, 1, 1, 0,   0, 2'd1, 2'd1, 4'd7));
    vecs.push_back(mk(0, 8'h00,       4'd0, 0, 1, 1, 0,   1, 2'd2, 2'd1, 4'd0));
    // Load with in_valid discards the bit; then 101 with idle gaps, overlap on
    vecs.push_back(mk(1, 8'b00000101, 4'd3, 1, 1, 1, 0,   0, 2'd2, 2'd1, 4'd0));
    vecs.push_back(mk(0, 8'h00,       4'd0, 0, 1, 1, 0,   0, 2'd2, 2'd1, 4'd1));
    vecs.push_back(mk(0, 8'h00,       4'd0, 0, 0, 1, 0,   0, 2'd2, 2'd1, 4'd1));
    vecs.push_back(mk(0, 8'h00,       4'd0, 0, 1, 0, 0,   0, 2'd2, 2'd1, 4'd2));
    vecs.push_back(mk(0, 8'h00,       4'd0, 0, 0, 0, 0,   0, 2'd2, 2'd1, 4'd2));
    vecs.push_back(mk(0, 8'h00,       4'd0, 0, 1, 1, 0,   1, 2'd3, 2'd2, 4'd3));
    vecs.push_back(mk(0, 8'h00,       4'd0, 0, 0, 0, 0,   0, 2'd3, 2'd2, 4'd3));
    // Length-1 pattern, non-overlap: five back-to-back matches saturating at 3
    vecs.push_back(mk(1, 8'b00000001, 4'd1, 0, 0, 0, 1,   0, 2'd0, 2'd1, 4'd0));
    vecs.push_back(mk(0, 8'h00,       4'd0, 0, 1, 1, 0,   1, 2'd1, 2'd1, 4'd0));
    vecs.push_back(mk(0, 8'h00,       4'd0, 0, 1, 1, 0,   1, 2'd2, 2'd1, 4'd0));
    vecs.push_back(mk(0, 8'h00,       4'd0, 0, 1, 1, 0,   1, 2'd3, 2'd1, 4'd0));
    vecs.push_back(mk(0, 8'h00,       4'd0, 0, 1, 1, 0,   1, 2'd3, 2'd1, 4'd0));
    vecs.push_back(mk(0, 8'h00,       4'd0, 0, 1, 1, 0,   1, 2'd3, 2'd1, 4'd0));
    vecs.push_back(mk(0, 8'h00,       4'd0, 0, 1, 0, 0,   0, 2'd3, 2'd2, 4'd1));
    // clr_cnt together with a match: pulse still issued, count cleared
    vecs.push_back(mk(0, 8'h00,       4'd0, 0, 1, 1, 1,   1, 2'd0, 2'd1, 4'd0));
    // Set up fill 3 ahead of the asynchronous reset
    vecs.push_back(mk(1, 8'b00001101, 4'd4, 0, 0, 0, 0,   0, 2'd0, 2'd1, 4'd0));
    vecs.push_back(mk(0, 8'h00,       4'd0, 0, 1, 1, 0,   0, 2'd0, 2'd1, 4'd1));
    vecs.push_back(mk(0, 8'h00,       4'd0, 0, 1, 1, 0,   0, 2'd0, 2'd1, 4'd2));
    vecs.push_back(mk(0, 8'h00,       4'd0, 0, 1, 0, 1,   0, 2'd0, 2'd1, 4'd3));

    bus.load = 1'b0; bus.pattern = '0; bus.pat_len = '0; bus.overlap = 1'b0;
    bus.in_valid = 1'b0; bus.w = 1'b0; bus.clr_cnt = 1'b0;
    resetn = 1'b0;
    #12;
    checkOutput("reset", 1'b0, '0, 2'd0, '0);
    @(negedge clock);
    resetn = 1'b1;
    @(posedge clock);
    #1;

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i]);
      checkOutput($sformatf("vec%0d", i), vecs[i].exp_match, vecs[i].exp_count,
                  vecs[i].exp_state, vecs[i].exp_fill);
    end

    // Asynchronous reset between edges clears everything without a clock
    #3;
    resetn = 1'b0;
    #1;
    checkOutput("async_reset", 1'b0, '0, 2'd0, '0);
    @(negedge clock);
    resetn = 1'b1;
    for (int i = 0; i < 5; i++) begin
      applyStimulus(mk(0, 8'h00, 4'd0, 0, 1, 1, 0, 0, 2'd0, 2'd0, 4'd0));
      checkOutput($sformatf("post_reset%0d", i), 1'b0, '0, 2'd0, '0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
